// File: rtl/ex_operand_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_issue_if
//  Description : Bundle between decode / later pipeline stages and the
//                ID/EX operand-issue block (decoded fields, writeback
//                snoop buses, ALU operands and EX-stage control).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_operand_issue_if #(
    parameter int XLEN = 32
);
    // Decode slot
    logic            id_valid_i;
    logic [4:0]      id_fn_i;
    logic [4:0]      id_rs1_i;
    logic [4:0]      id_rs2_i;
    logic [4:0]      id_rd_i;
    logic [XLEN-1:0] id_rs1_data_i;
    logic [XLEN-1:0] id_rs2_data_i;
    logic [XLEN-1:0] id_imm_i;
    logic [XLEN-1:0] id_pc_i;
    logic            id_op1_pc_i;
    logic            id_op2_imm_i;
    logic            id_wb_en_i;
    logic            id_is_load_i;
    logic            flush_i;
    // Writeback snoop from EX/MEM and MEM/WB
    logic [4:0]      exm_rd_i;
    logic            exm_wb_en_i;
    logic [XLEN-1:0] exm_result_i;
    logic [4:0]      mwb_rd_i;
    logic            mwb_wb_en_i;
    logic [XLEN-1:0] mwb_result_i;
    // Results
    logic            stall_id_o;
    logic [4:0]      alu_fn_o;
    logic [XLEN-1:0] alu_src1_o;
    logic [XLEN-1:0] alu_src2_o;
    logic [XLEN-1:0] ex_store_data_o;
    logic            ex_valid_o;
    logic [4:0]      ex_rd_o;
    logic            ex_wb_en_o;
    logic            ex_is_load_o;

    // Pipeline side driving decode fields and consuming EX results
    modport master (
        output id_valid_i, id_fn_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i,
               id_op1_pc_i, id_op2_imm_i, id_wb_en_i, id_is_load_i, flush_i,
               exm_rd_i, exm_wb_en_i, exm_result_i,
               mwb_rd_i, mwb_wb_en_i, mwb_result_i,
        input  stall_id_o, alu_fn_o, alu_src1_o, alu_src2_o, ex_store_data_o,
               ex_valid_o, ex_rd_o, ex_wb_en_o, ex_is_load_o
    );

    // Operand-issue block side
    modport slave (
        input  id_valid_i, id_fn_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i,
               id_op1_pc_i, id_op2_imm_i, id_wb_en_i, id_is_load_i, flush_i,
               exm_rd_i, exm_wb_en_i, exm_result_i,
               mwb_rd_i, mwb_wb_en_i, mwb_result_i,
        output stall_id_o, alu_fn_o, alu_src1_o, alu_src2_o, ex_store_data_o,
               ex_valid_o, ex_rd_o, ex_wb_en_o, ex_is_load_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_issue
//  Description : ID/EX pipeline register feeding the ALU. Captures decoded
//                fields, resolves source operands through EX/MEM and MEM/WB
//                forwarding and raises stall_id on load-use (or, with
//                forwarding disabled, on any pending RAW) hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_operand_issue #(
    parameter int         XLEN   = 32,
    parameter bit         FWD_EN = 1'b1,
    parameter logic [4:0] ALU_X  = 5'h1F
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ex_operand_issue_if.slave   bus
);

    // EX-stage control
    logic            ex_valid_q,   ex_valid_d;
    logic [4:0]      ex_rd_q,      ex_rd_d;
    logic            ex_wb_en_q,   ex_wb_en_d;
    logic            ex_is_load_q, ex_is_load_d;
    logic [4:0]      alu_fn_q,     alu_fn_d;
    // EX-stage operand sources
    logic [4:0]      rs1_q,        rs1_d;
    logic [4:0]      rs2_q,        rs2_d;
    logic [XLEN-1:0] rs1_data_q,   rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,   rs2_data_d;
    logic [XLEN-1:0] imm_q,        imm_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic            op1_pc_q,     op1_pc_d;
    logic            op2_imm_q,    op2_imm_d;

    logic            w_load_use;
    logic            w_raw_hazard;
    logic            w_stall;
    logic            w_capture;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // Load-use: the load in EX has no data yet, so a consumer in ID must wait one cycle.
    // rs2 is always treated as used because stores need it as data.
    always_comb begin
        w_load_use = 1'b0;
        if (bus.id_valid_i && ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0)) begin
            w_load_use = ((ex_rd_q == bus.id_rs1_i) && !bus.id_op1_pc_i) ||
                         (ex_rd_q == bus.id_rs2_i);
        end
    end

    generate
        if (FWD_EN) begin : g_fwd
            // No extra RAW stalls when forwarding resolves them
            assign w_raw_hazard = 1'b0;

            // rs1 forward select: x0 never forwarded, EX/MEM is younger than MEM/WB
            always_comb begin
                w_fwd_rs1 = rs1_data_q;
                if (rs1_q != 5'd0) begin
                    if (bus.exm_wb_en_i && (bus.exm_rd_i == rs1_q)) begin
                        w_fwd_rs1 = bus.exm_result_i;
                    end else if (bus.mwb_wb_en_i && (bus.mwb_rd_i == rs1_q)) begin
                        w_fwd_rs1 = bus.mwb_result_i;
                    end
                end
            end

            // rs2 forward select, same priority as rs1
            always_comb begin
                w_fwd_rs2 = rs2_data_q;
                if (rs2_q != 5'd0) begin
                    if (bus.exm_wb_en_i && (bus.exm_rd_i == rs2_q)) begin
                        w_fwd_rs2 = bus.exm_result_i;
                    end else if (bus.mwb_wb_en_i && (bus.mwb_rd_i == rs2_q)) begin
                        w_fwd_rs2 = bus.mwb_result_i;
                    end
                end
            end
        end else begin : g_nofwd
            logic w_hit_ex;
            logic w_hit_exm;
            logic w_hit_mwb;

            // Without forwarding the regfile value is only trustworthy once no
            // older in-flight writer targets a used source register.
            always_comb begin
                w_hit_ex  = ex_valid_q && ex_wb_en_q && (ex_rd_q != 5'd0) &&
                            (((ex_rd_q == bus.id_rs1_i) && !bus.id_op1_pc_i) ||
                             (ex_rd_q == bus.id_rs2_i));
                w_hit_exm = bus.exm_wb_en_i && (bus.exm_rd_i != 5'd0) &&
                            (((bus.exm_rd_i == bus.id_rs1_i) && !bus.id_op1_pc_i) ||
                             (bus.exm_rd_i == bus.id_rs2_i));
                w_hit_mwb = bus.mwb_wb_en_i && (bus.mwb_rd_i != 5'd0) &&
                            (((bus.mwb_rd_i == bus.id_rs1_i) && !bus.id_op1_pc_i) ||
                             (bus.mwb_rd_i == bus.id_rs2_i));
                w_raw_hazard = bus.id_valid_i && (w_hit_ex || w_hit_exm || w_hit_mwb);
            end

            assign w_fwd_rs1 = rs1_data_q;
            assign w_fwd_rs2 = rs2_data_q;
        end
    endgenerate

    assign w_stall   = w_load_use || w_raw_hazard;
    // A real instruction enters EX only when not killed and not held back
    assign w_capture = bus.id_valid_i && !bus.flush_i && !w_stall;

    // Next-state: control becomes a bubble unless captured; operand fields
    // follow ID every cycle (they are inert while the control says bubble).
    always_comb begin
        ex_valid_d   = w_capture;
        ex_wb_en_d   = w_capture && bus.id_wb_en_i;
        ex_is_load_d = w_capture && bus.id_is_load_i;
        ex_rd_d      = w_capture ? bus.id_rd_i : 5'd0;
        alu_fn_d     = w_capture ? bus.id_fn_i : ALU_X;
        rs1_d        = bus.id_rs1_i;
        rs2_d        = bus.id_rs2_i;
        rs1_data_d   = bus.id_rs1_data_i;
        rs2_data_d   = bus.id_rs2_data_i;
        imm_d        = bus.id_imm_i;
        pc_d         = bus.id_pc_i;
        op1_pc_d     = bus.id_op1_pc_i;
        op2_imm_d    = bus.id_op2_imm_i;
    end

    // ID/EX pipeline register with synchronous reset to an empty bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_wb_en_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_rd_q      <= 5'd0;
            alu_fn_q     <= ALU_X;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            op1_pc_q     <= 1'b0;
            op2_imm_q    <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_wb_en_q   <= ex_wb_en_d;
            ex_is_load_q <= ex_is_load_d;
            ex_rd_q      <= ex_rd_d;
            alu_fn_q     <= alu_fn_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            op1_pc_q     <= op1_pc_d;
            op2_imm_q    <= op2_imm_d;
        end
    end

    assign bus.stall_id_o      = w_stall;
    assign bus.alu_fn_o        = alu_fn_q;
    assign bus.alu_src1_o      = op1_pc_q  ? pc_q  : w_fwd_rs1;
    assign bus.alu_src2_o      = op2_imm_q ? imm_q : w_fwd_rs2;
    assign bus.ex_store_data_o = w_fwd_rs2;
    assign bus.ex_valid_o      = ex_valid_q;
    assign bus.ex_rd_o         = ex_rd_q;
    assign bus.ex_wb_en_o      = ex_wb_en_q;
    assign bus.ex_is_load_o    = ex_is_load_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_operand_issue
//  Description : Directed self-checking bench for ex_operand_issue, with one
//                forwarding instance and one no-forwarding instance sharing
//                the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_operand_issue;
    localparam int         XLEN  = 32;
    localparam logic [4:0] ALU_X = 5'h1F;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ex_operand_issue_if #(.XLEN(XLEN)) bif ();
    ex_operand_issue_if #(.XLEN(XLEN)) nif ();

    ex_operand_issue #(.XLEN(XLEN), .FWD_EN(1'b1), .ALU_X(ALU_X)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    ex_operand_issue #(.XLEN(XLEN), .FWD_EN(1'b0), .ALU_X(ALU_X)) u_dut_nofwd (
        .clk (clk),
        .rst (rst),
        .bus (nif)
    );

    // Mirror the stimulus onto the no-forwarding instance
    assign nif.id_valid_i    = bif.id_valid_i;
    assign nif.id_fn_i       = bif.id_fn_i;
    assign nif.id_rs1_i      = bif.id_rs1_i;
    assign nif.id_rs2_i      = bif.id_rs2_i;
    assign nif.id_rd_i       = bif.id_rd_i;
    assign nif.id_rs1_data_i = bif.id_rs1_data_i;
    assign nif.id_rs2_data_i = bif.id_rs2_data_i;
    assign nif.id_imm_i      = bif.id_imm_i;
    assign nif.id_pc_i       = bif.id_pc_i;
    assign nif.id_op1_pc_i   = bif.id_op1_pc_i;
    assign nif.id_op2_imm_i  = bif.id_op2_imm_i;
    assign nif.id_wb_en_i    = bif.id_wb_en_i;
    assign nif.id_is_load_i  = bif.id_is_load_i;
    assign nif.flush_i       = bif.flush_i;
    assign nif.exm_rd_i      = bif.exm_rd_i;
    assign nif.exm_wb_en_i   = bif.exm_wb_en_i;
    assign nif.exm_result_i  = bif.exm_result_i;
    assign nif.mwb_rd_i      = bif.mwb_rd_i;
    assign nif.mwb_wb_en_i   = bif.mwb_wb_en_i;
    assign nif.mwb_result_i  = bif.mwb_result_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.id_valid_i    = 1'b0;
        bif.id_fn_i       = 5'd0;
        bif.id_rs1_i      = 5'd0;
        bif.id_rs2_i      = 5'd0;
        bif.id_rd_i       = 5'd0;
        bif.id_rs1_data_i = '0;
        bif.id_rs2_data_i = '0;
        bif.id_imm_i      = '0;
        bif.id_pc_i       = '0;
        bif.id_op1_pc_i   = 1'b0;
        bif.id_op2_imm_i  = 1'b0;
        bif.id_wb_en_i    = 1'b0;
        bif.id_is_load_i  = 1'b0;
        bif.flush_i       = 1'b0;
        bif.exm_rd_i      = 5'd0;
        bif.exm_wb_en_i   = 1'b0;
        bif.exm_result_i  = '0;
        bif.mwb_rd_i      = 5'd0;
        bif.mwb_wb_en_i   = 1'b0;
        bif.mwb_result_i  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst               = 1'b1;
        bif.id_valid_i    = 1'b1;
        bif.id_wb_en_i    = 1'b1;
        bif.id_is_load_i  = 1'b1;
        bif.id_fn_i       = 5'd3;
        bif.id_rd_i       = 5'd9;
        bif.id_rs1_data_i = 32'h1111_1111;
        bif.id_rs2_data_i = 32'h2222_2222;
        tick();
        tick();
        n_checks++; if (bif.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %0h expected 0", bif.ex_valid_o); end
        n_checks++; if (bif.ex_wb_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_ex_wb_en: got %0h expected 0", bif.ex_wb_en_o); end
        n_checks++; if (bif.ex_is_load_o !== 1'b0) begin n_fail++; $display("FAIL reset_ex_is_load: got %0h expected 0", bif.ex_is_load_o); end
        n_checks++; if (bif.alu_fn_o !== ALU_X) begin n_fail++; $display("FAIL reset_alu_fn: got %h expected %h", bif.alu_fn_o, ALU_X); end
        n_checks++; if (bif.alu_src1_o !== 32'h0) begin n_fail++; $display("FAIL reset_src1: got %h expected 0", bif.alu_src1_o); end
        n_checks++; if (bif.alu_src2_o !== 32'h0) begin n_fail++; $display("FAIL reset_src2: got %h expected 0", bif.alu_src2_o); end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_exm_fwd();
        clear_inputs();
        bif.id_valid_i    = 1'b1;
        bif.id_fn_i       = 5'd3;
        bif.id_rs1_i      = 5'd5;
        bif.id_rs2_i      = 5'd6;
        bif.id_rd_i       = 5'd9;
        bif.id_wb_en_i    = 1'b1;
        bif.id_rs1_data_i = 32'h0000_AAAA;
        bif.id_rs2_data_i = 32'h0000_BBBB;
        tick();
        bif.exm_rd_i     = 5'd5;
        bif.exm_wb_en_i  = 1'b1;
        bif.exm_result_i = 32'h0000_1234;
        bif.mwb_rd_i     = 5'd5;
        bif.mwb_wb_en_i  = 1'b1;
        bif.mwb_result_i = 32'h0000_DEAD;
        #1;
        n_checks++; if (bif.alu_src1_o !== 32'h0000_1234) begin n_fail++; $display("FAIL exm_fwd_src1: got %h expected 00001234", bif.alu_src1_o); end
        n_checks++; if (bif.alu_src2_o !== 32'h0000_BBBB) begin n_fail++; $display("FAIL exm_fwd_src2_nohit: got %h expected 0000bbbb", bif.alu_src2_o); end
        n_checks++; if (bif.alu_fn_o !== 5'd3) begin n_fail++; $display("FAIL exm_fwd_fn: got %h expected 03", bif.alu_fn_o); end
        n_checks++; if (bif.ex_valid_o !== 1'b1 || bif.ex_rd_o !== 5'd9 || bif.ex_wb_en_o !== 1'b1)
            begin n_fail++; $display("FAIL exm_fwd_ctrl: got v=%0h rd=%0d wb=%0h expected v=1 rd=9 wb=1", bif.ex_valid_o, bif.ex_rd_o, bif.ex_wb_en_o); end
        bif.exm_wb_en_i = 1'b0;
        #1;
        n_checks++; if (bif.alu_src1_o !== 32'h0000_DEAD) begin n_fail++; $display("FAIL mwb_fwd_src1: got %h expected 0000dead", bif.alu_src1_o); end
        bif.mwb_rd_i = 5'd6;
        #1;
        n_checks++; if (bif.alu_src1_o !== 32'h0000_AAAA) begin n_fail++; $display("FAIL nofwd_src1: got %h expected 0000aaaa", bif.alu_src1_o); end
        n_checks++; if (bif.ex_store_data_o !== 32'h0000_DEAD) begin n_fail++; $display("FAIL mwb_fwd_store: got %h expected 0000dead", bif.ex_store_data_o); end
        // x0 is never forwarded
        clear_inputs();
        bif.id_valid_i    = 1'b1;
        bif.id_fn_i       = 5'd4;
        bif.id_rs1_i      = 5'd0;
        bif.id_rs2_i      = 5'd0;
        bif.id_rs1_data_i = 32'h0000_5555;
        tick();
        bif.exm_rd_i     = 5'd0;
        bif.exm_wb_en_i  = 1'b1;
        bif.exm_result_i = 32'h0000_1234;
        #1;
        n_checks++; if (bif.alu_src1_o !== 32'h0000_5555) begin n_fail++; $display("FAIL x0_no_fwd: got %h expected 00005555", bif.alu_src1_o); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        // lw x7, 8(x2)
        bif.id_valid_i    = 1'b1;
        bif.id_is_load_i  = 1'b1;
        bif.id_wb_en_i    = 1'b1;
        bif.id_rd_i       = 5'd7;
        bif.id_rs1_i      = 5'd2;
        bif.id_rs1_data_i = 32'h0000_0100;
        bif.id_op2_imm_i  = 1'b1;
        bif.id_imm_i      = 32'd8;
        bif.id_fn_i       = 5'd0;
        tick();
        n_checks++; if (bif.ex_is_load_o !== 1'b1) begin n_fail++; $display("FAIL lu_ex_is_load: got %0h expected 1", bif.ex_is_load_o); end
        // add x8, x1, x7
        bif.id_is_load_i  = 1'b0;
        bif.id_op2_imm_i  = 1'b0;
        bif.id_imm_i      = '0;
        bif.id_rd_i       = 5'd8;
        bif.id_rs1_i      = 5'd1;
        bif.id_rs2_i      = 5'd7;
        bif.id_rs1_data_i = 32'h0000_0011;
        bif.id_rs2_data_i = 32'h0000_0022;
        bif.id_fn_i       = 5'd1;
        #1;
        n_checks++; if (bif.stall_id_o !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0h expected 1", bif.stall_id_o); end
        tick();
        n_checks++; if (bif.ex_valid_o !== 1'b0 || bif.ex_wb_en_o !== 1'b0 || bif.ex_rd_o !== 5'd0 || bif.alu_fn_o !== ALU_X)
            begin n_fail++; $display("FAIL lu_bubble: got v=%0h wb=%0h rd=%0d fn=%h expected v=0 wb=0 rd=0 fn=%h", bif.ex_valid_o, bif.ex_wb_en_o, bif.ex_rd_o, bif.alu_fn_o, ALU_X); end
        n_checks++; if (bif.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL lu_single_stall: got %0h expected 0", bif.stall_id_o); end
        tick();
        // load now in MEM/WB, bubble in EX/MEM
        bif.mwb_rd_i     = 5'd7;
        bif.mwb_wb_en_i  = 1'b1;
        bif.mwb_result_i = 32'h0000_CAFE;
        #1;
        n_checks++; if (bif.ex_valid_o !== 1'b1 || bif.ex_rd_o !== 5'd8 || bif.alu_fn_o !== 5'd1)
            begin n_fail++; $display("FAIL lu_add_enter: got v=%0h rd=%0d fn=%h expected v=1 rd=8 fn=01", bif.ex_valid_o, bif.ex_rd_o, bif.alu_fn_o); end
        n_checks++; if (bif.alu_src2_o !== 32'h0000_CAFE) begin n_fail++; $display("FAIL lu_fwd_src2: got %h expected 0000cafe", bif.alu_src2_o); end
        n_checks++; if (bif.alu_src1_o !== 32'h0000_0011) begin n_fail++; $display("FAIL lu_src1: got %h expected 00000011", bif.alu_src1_o); end
        clear_inputs();
    endtask

    task automatic test_flush();
        clear_inputs();
        bif.id_valid_i = 1'b1;
        bif.id_wb_en_i = 1'b1;
        bif.id_rd_i    = 5'd4;
        bif.id_fn_i    = 5'd2;
        bif.flush_i    = 1'b1;
        tick();
        n_checks++; if (bif.ex_valid_o !== 1'b0 || bif.ex_wb_en_o !== 1'b0 || bif.ex_rd_o !== 5'd0)
            begin n_fail++; $display("FAIL flush_bubble: got v=%0h wb=%0h rd=%0d expected v=0 wb=0 rd=0", bif.ex_valid_o, bif.ex_wb_en_o, bif.ex_rd_o); end
        n_checks++; if (bif.alu_fn_o !== ALU_X) begin n_fail++; $display("FAIL flush_fn: got %h expected %h", bif.alu_fn_o, ALU_X); end
        clear_inputs();
    endtask

    task automatic test_imm_pc();
        clear_inputs();
        bif.id_valid_i    = 1'b1;
        bif.id_op1_pc_i   = 1'b1;
        bif.id_pc_i       = 32'h0000_0080;
        bif.id_op2_imm_i  = 1'b1;
        bif.id_imm_i      = 32'hFFFF_FFFC;
        bif.id_rs1_i      = 5'd3;
        bif.id_rs2_i      = 5'd6;
        bif.id_rs2_data_i = 32'h0000_0077;
        tick();
        bif.exm_rd_i     = 5'd6;
        bif.exm_wb_en_i  = 1'b1;
        bif.exm_result_i = 32'h0000_600D;
        #1;
        n_checks++; if (bif.alu_src1_o !== 32'h0000_0080) begin n_fail++; $display("FAIL pc_src1: got %h expected 00000080", bif.alu_src1_o); end
        n_checks++; if (bif.alu_src2_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL imm_src2: got %h expected fffffffc", bif.alu_src2_o); end
        n_checks++; if (bif.ex_store_data_o !== 32'h0000_600D) begin n_fail++; $display("FAIL imm_store_data: got %h expected 0000600d", bif.ex_store_data_o); end
        clear_inputs();
    endtask

    task automatic test_no_fwd();
        clear_inputs();
        tick();
        bif.id_valid_i    = 1'b1;
        bif.id_fn_i       = 5'd2;
        bif.id_rs1_i      = 5'd3;
        bif.id_rs2_i      = 5'd4;
        bif.id_rd_i       = 5'd10;
        bif.id_wb_en_i    = 1'b1;
        bif.id_rs1_data_i = 32'h0000_3333;
        bif.id_rs2_data_i = 32'h0000_4444;
        bif.mwb_rd_i      = 5'd3;
        bif.mwb_wb_en_i   = 1'b1;
        bif.mwb_result_i  = 32'h0000_9999;
        #1;
        n_checks++; if (nif.stall_id_o !== 1'b1) begin n_fail++; $display("FAIL nf_mwb_stall: got %0h expected 1", nif.stall_id_o); end
        n_checks++; if (bif.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL fwd_no_stall: got %0h expected 0", bif.stall_id_o); end
        tick();
        n_checks++; if (nif.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL nf_bubble: got %0h expected 0", nif.ex_valid_o); end
        n_checks++; if (nif.stall_id_o !== 1'b1) begin n_fail++; $display("FAIL nf_stall_held: got %0h expected 1", nif.stall_id_o); end
        bif.mwb_wb_en_i = 1'b0;
        #1;
        n_checks++; if (nif.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL nf_stall_clear: got %0h expected 0", nif.stall_id_o); end
        tick();
        n_checks++; if (nif.ex_valid_o !== 1'b1 || nif.ex_rd_o !== 5'd10) begin n_fail++; $display("FAIL nf_enter: got v=%0h rd=%0d expected v=1 rd=10", nif.ex_valid_o, nif.ex_rd_o); end
        n_checks++; if (nif.alu_src1_o !== 32'h0000_3333) begin n_fail++; $display("FAIL nf_src1: got %h expected 00003333", nif.alu_src1_o); end
        // Consumer of the instruction now sitting in EX
        bif.id_rs1_i = 5'd1;
        bif.id_rs2_i = 5'd10;
        #1;
        n_checks++; if (nif.stall_id_o !== 1'b1) begin n_fail++; $display("FAIL nf_ex_stall: got %0h expected 1", nif.stall_id_o); end
        n_checks++; if (bif.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL fwd_ex_no_stall: got %0h expected 0", bif.stall_id_o); end
        // Writers to x0 never cause a hazard
        bif.id_rs1_i    = 5'd0;
        bif.id_rs2_i    = 5'd0;
        bif.mwb_rd_i    = 5'd0;
        bif.mwb_wb_en_i = 1'b1;
        bif.exm_rd_i    = 5'd0;
        bif.exm_wb_en_i = 1'b1;
        #1;
        n_checks++; if (nif.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL nf_x0_no_stall: got %0h expected 0", nif.stall_id_o); end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_exm_fwd();
        test_load_use();
        test_flush();
        test_imm_pc();
        test_no_fwd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
